mem_lsu_initiator: RTL

- In-order load/store initiator that drives one port of the pipeline's dual-port block RAM.
- The RAM has asynchronous read and synchronous write.
- Pipeline stages issue tagged load/store requests over a valid/ready handshake. Requests are buffered in a DEPTH-entry FIFO and drained one per cycle onto the RAM port.
- Load data is returned through a registered, back-pressurable response channel.

---
 rtl/mem_lsu_initiator.sv | 84 ++++++++
 1 files changed

// File: rtl/mem_lsu_initiator.sv
// mem_lsu_initiator: in-order tagged load/store FIFO draining onto an async-read/sync-write RAM port
module mem_lsu_initiator #(
  parameter int WORD_SIZE = 16,
  parameter int MEM_SIZE  = 32,
  parameter int ADDR_SIZE = $clog2(MEM_SIZE),
  parameter int DEPTH     = 4,
  parameter int TAG_SIZE  = 4
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_store,
  input  logic [ADDR_SIZE-1:0] i_req_addr,
  input  logic [WORD_SIZE-1:0] i_req_wdata,
  input  logic [TAG_SIZE-1:0]  i_req_tag,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [WORD_SIZE-1:0] o_rsp_data,
  output logic [TAG_SIZE-1:0]  o_rsp_tag,
  output logic                 o_mem_write_en,
  output logic [ADDR_SIZE-1:0] o_mem_write_addr,
  output logic [WORD_SIZE-1:0] o_mem_write_data,
  output logic                 o_mem_read_en,
  output logic [ADDR_SIZE-1:0] o_mem_read_addr,
  input  logic [WORD_SIZE-1:0] i_mem_read_data,
  output logic                 o_idle
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0]     q_store;
  logic [ADDR_SIZE-1:0] q_addr  [DEPTH];
  logic [WORD_SIZE-1:0] q_wdata [DEPTH];
  logic [TAG_SIZE-1:0]  q_tag   [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;
  logic                 empty, push, pop, issue_store, issue_load;
  logic [ADDR_SIZE-1:0] head_addr;
  logic [WORD_SIZE-1:0] head_wdata;
  always_comb begin
    empty            = count == '0;
    o_req_ready      = !count[PW];
    push             = i_req_valid && o_req_ready;
    issue_store      = !empty && q_store[rd_ptr];
    issue_load       = !empty && !q_store[rd_ptr] && (!o_rsp_valid || i_rsp_ready);
    pop              = issue_store || issue_load;
    head_addr        = empty ? '0 : q_addr[rd_ptr];
    head_wdata       = empty ? '0 : q_wdata[rd_ptr];
    o_mem_write_en   = issue_store;
    o_mem_write_addr = head_addr;
    o_mem_write_data = head_wdata;
    o_mem_read_en    = issue_load;
    o_mem_read_addr  = head_addr;
    o_idle           = empty && !o_rsp_valid;
  end
  always_ff @(posedge i_CLK) begin
    if (push) begin
      q_store[wr_ptr] <= i_req_store;
      q_addr[wr_ptr]  <= i_req_addr;
      q_wdata[wr_ptr] <= i_req_wdata;
      q_tag[wr_ptr]   <= i_req_tag;
    end
  end
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_tag   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (issue_load) begin
        o_rsp_valid <= 1'b1;
        o_rsp_data  <= i_mem_read_data;
        o_rsp_tag   <= q_tag[rd_ptr];
      end else if (i_rsp_ready) begin
        o_rsp_valid <= 1'b0;
      end
    end
  end
endmodule
